// File: rtl/keyexp_multi_if.sv
// keyexp_multi_if: key-load, status and round-key read signals of the key-expansion engine
interface keyexp_multi_if #(
   parameter int MAX_NK = 8
);
   localparam int MAX_NR = MAX_NK + 6;
   logic                  iStartKey;
   logic [1:0]            iKeyLen;
   logic [32*MAX_NK-1:0]  iKey;
   logic                  iEnd;
   logic [3:0]            iRdRound;
   logic [127:0]          oRdKey;
   logic [MAX_NR:0]       oKeyRoundReady;
   logic                  oBusy;
   logic                  oDone;
   logic                  oKeyErr;
   modport master (
      output iStartKey, iKeyLen, iKey, iEnd, iRdRound,
      input  oRdKey, oKeyRoundReady, oBusy, oDone, oKeyErr
   );
   modport slave (
      input  iStartKey, iKeyLen, iKey, iEnd, iRdRound,
      output oRdKey, oKeyRoundReady, oBusy, oDone, oKeyErr
   );
endinterface

// File: rtl/keyexp_multi.sv
// keyexp_multi: AES-128/192/256 key expansion, one schedule word per cycle, registered round-key read.
// Define KEYEXP_ZEROIZE_EN to wipe the word store and latched mode when leaving RUN/DONE via iEnd.
module keyexp_multi #(
   parameter int MAX_NK = 8
) (
   input logic           iClk,
   input logic           iRst,
   keyexp_multi_if.slave bus
);
   localparam int MAX_NR = MAX_NK + 6;
   localparam int RW     = MAX_NR + 1;
   localparam int DEPTH  = 4 * RW;
   localparam int IW     = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         r_state, w_next;
   logic [31:0]    r_w [DEPTH];
   logic [IW-1:0]  r_i;
   logic [3:0]     r_nk, r_nr, r_j;
   logic [7:0]     r_rcon;
   logic [RW-1:0]  r_ready;
   logic [127:0]   r_rd;
   logic           r_err;
   logic           w_start, w_reject, w_step, w_clear;
   logic [3:0]     w_nk;
   logic [IW-1:0]  w_rd_base;
   logic [31:0]    w_prev, w_sub, w_t, w_new;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         p = p ^ (b[k] ? x : 8'h00);
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // multiplicative inverse as x^254, then the FIPS-197 affine transform
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq, inv;
      sq  = x;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gmul(sq, sq);
         inv = gmul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   assign w_nk      = 4'd4 + {1'b0, bus.iKeyLen, 1'b0};
   assign w_rd_base = IW'({bus.iRdRound, 2'b00});
   assign w_prev    = r_w[r_i - IW'(1)];
   assign w_sub     = sub_word((r_j == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev);
   assign w_t       = (r_j == 4'd0) ? w_sub ^ {r_rcon, 24'h0} :
                      (r_nk == 4'd8 && r_j == 4'd4) ? w_sub : w_prev;
   assign w_new     = r_w[r_i - IW'(r_nk)] ^ w_t;

   always_comb begin
      w_next   = r_state;
      w_start  = 1'b0;
      w_reject = 1'b0;
      w_step   = 1'b0;
      w_clear  = 1'b0;
      case (r_state)
         IDLE: if (bus.iStartKey) begin
            w_reject = bus.iKeyLen == 2'd3 || w_nk > 4'(MAX_NK);
            w_start  = !w_reject;
            w_next   = w_reject ? IDLE : RUN;
         end
         RUN: begin
            w_clear = bus.iEnd;
            w_step  = !bus.iEnd;
            w_next  = bus.iEnd ? IDLE : (r_i == IW'({r_nr, 2'b11})) ? DONE : RUN;
         end
         DONE: begin
            w_clear = bus.iEnd;
            w_next  = bus.iEnd ? IDLE : DONE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_state <= IDLE;
         r_i     <= '0;
         r_nk    <= '0;
         r_nr    <= '0;
         r_j     <= '0;
         r_rcon  <= '0;
         r_ready <= '0;
         r_rd    <= '0;
         r_err   <= 1'b0;
         for (int k = 0; k < DEPTH; k++) r_w[k] <= '0;
      end else begin
         r_state <= w_next;
         r_err   <= w_reject;
         r_rd    <= (bus.iRdRound > r_nr) ? '0 :
                    {r_w[w_rd_base + IW'(3)], r_w[w_rd_base + IW'(2)], r_w[w_rd_base + IW'(1)], r_w[w_rd_base]};
         if (w_start) begin
            r_nk    <= w_nk;
            r_nr    <= w_nk + 4'd6;
            r_i     <= IW'(w_nk);
            r_j     <= '0;
            r_rcon  <= 8'h01;
            r_ready <= (w_nk == 4'd8) ? RW'(3) : RW'(1);
            for (int k = 0; k < MAX_NK; k++) if (4'(k) < w_nk) r_w[k] <= bus.iKey[32*k +: 32];
         end
         if (w_step) begin
            r_w[r_i] <= w_new;
            r_i      <= r_i + IW'(1);
            r_j      <= (r_j == r_nk - 4'd1) ? 4'd0 : r_j + 4'd1;
            if (r_j == 4'd0) r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
            if (r_i[1:0] == 2'b11) r_ready[r_i[IW-1:2]] <= 1'b1;
         end
         if (w_clear) begin
            r_ready <= '0;
`ifdef KEYEXP_ZEROIZE_EN
            r_nk <= '0;
            r_nr <= '0;
            for (int k = 0; k < DEPTH; k++) r_w[k] <= '0;
`else
`endif
         end
      end
   end

   assign bus.oRdKey         = r_rd;
   assign bus.oKeyRoundReady = r_ready;
   assign bus.oBusy          = r_state == RUN;
   assign bus.oDone          = r_state == DONE;
   assign bus.oKeyErr        = r_err;
endmodule

// File: tb/tb_keyexp_multi.sv
// tb_keyexp_multi: random and directed stimulus checked every cycle against a FIPS-197 level model.
module tb_keyexp_multi;
   localparam int MAX_NK = 8;
   localparam int MAX_NR = MAX_NK + 6;

   localparam logic [255:0] K128 = {128'h0, 32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
   localparam logic [255:0] K192 = {64'h0, 32'h522c6b7b, 32'h62f8ead2, 32'h809079e5, 32'hc810f32b,
                                    32'hda0e6452, 32'h8e73b0f7};
   localparam logic [255:0] K256 = {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
                                    32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};
   localparam logic [127:0] R10_128 = {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8};

   logic iClk = 1'b0;
   logic iRst = 1'b1;
   always #5 iClk = ~iClk;

   keyexp_multi_if #(.MAX_NK(MAX_NK)) bus ();
   keyexp_multi_if #(.MAX_NK(4)) bus4 ();
   keyexp_multi #(.MAX_NK(MAX_NK)) dut (.iClk(iClk), .iRst(iRst), .bus(bus));
   keyexp_multi #(.MAX_NK(4)) dut4 (.iClk(iClk), .iRst(iRst), .bus(bus4));

   assign bus4.iStartKey = bus.iStartKey;
   assign bus4.iKeyLen   = bus.iKeyLen;
   assign bus4.iKey      = bus.iKey[127:0];
   assign bus4.iEnd      = bus.iEnd;
   assign bus4.iRdRound  = bus.iRdRound;

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_en = 1'b0;

   logic [7:0]  rcon_t [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   logic [7:0]  sbox_t [256];
   logic [31:0] sched [64];
   logic [31:0] m_w [64];
   int          m_state, m_nk, m_nr, m_cnt;
   logic [127:0] exp_rd;
   logic [MAX_NR:0] exp_ready;
   logic        exp_busy, exp_done, exp_err;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box by brute-force inverse search plus bitwise affine map
   task automatic build_sbox();
      logic [7:0] inv, s, c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int b = 0; b < 8; b++)
            s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
         sbox_t[x] = s;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
   endfunction

   task automatic expand(input logic [255:0] key, input int nk);
      logic [31:0] t;
      for (int i = 0; i < 64; i++) sched[i] = '0;
      for (int i = 0; i < nk; i++) sched[i] = key[32*i +: 32];
      for (int i = nk; i < 4 * (nk + 7); i++) begin
         t = sched[i-1];
         if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/nk], 24'h0};
         else if (nk == 8 && i % 8 == 4) t = subw(t);
         sched[i] = sched[i-nk] ^ t;
      end
   endtask

   task automatic zeroize();
`ifdef KEYEXP_ZEROIZE_EN
      m_nk = 0;
      m_nr = 0;
      for (int k = 0; k < 64; k++) m_w[k] = '0;
`else
`endif
   endtask

   // spec-level model: advances by one clock edge using the inputs presented at that edge
   task automatic model_update();
      int rd, nk;
      rd = int'(bus.iRdRound);
      exp_rd = (rd > m_nr) ? '0 : {m_w[4*rd+3], m_w[4*rd+2], m_w[4*rd+1], m_w[4*rd]};
      exp_err = 1'b0;
      if (iRst) begin
         m_state = 0; m_nk = 0; m_nr = 0; m_cnt = 0; exp_rd = '0;
         for (int k = 0; k < 64; k++) m_w[k] = '0;
      end else if (m_state == 0) begin
         if (bus.iStartKey) begin
            nk = 4 + 2 * int'(bus.iKeyLen);
            if (bus.iKeyLen == 2'd3 || nk > MAX_NK) exp_err = 1'b1;
            else begin
               m_nk = nk; m_nr = nk + 6; m_cnt = nk; m_state = 1;
               expand(bus.iKey, nk);
               for (int j = 0; j < nk; j++) m_w[j] = sched[j];
            end
         end
      end else if (bus.iEnd) begin
         m_state = 0;
         zeroize();
      end else if (m_state == 1) begin
         m_w[m_cnt] = sched[m_cnt];
         m_cnt++;
         if (m_cnt == 4 * (m_nr + 1)) m_state = 2;
      end
      exp_busy = m_state == 1;
      exp_done = m_state == 2;
      for (int r = 0; r <= MAX_NR; r++) exp_ready[r] = m_state != 0 && 4 * r + 3 < m_cnt;
   endtask

   task automatic step();
      @(posedge iClk);
      model_update();
      #1;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         bus.iRdRound = 4'($urandom_range(0, 15));
         step();
      end
   endtask

   task automatic start(input logic [255:0] key, input logic [1:0] len);
      bus.iKey = key;
      bus.iKeyLen = len;
      bus.iStartKey = 1'b1;
      step();
      bus.iStartKey = 1'b0;
   endtask

   always @(negedge iClk) if (chk_en) begin
      check("rdkey", bus.oRdKey, exp_rd);
      check("ready", 128'(bus.oKeyRoundReady), 128'(exp_ready));
      check("busy", 128'(bus.oBusy), 128'(exp_busy));
      check("done", 128'(bus.oDone), 128'(exp_done));
      check("keyerr", 128'(bus.oKeyErr), 128'(exp_err));
   end

   initial begin
      bus.iStartKey = 1'b0; bus.iKeyLen = 2'd0; bus.iKey = '0; bus.iEnd = 1'b0; bus.iRdRound = 4'd0;
      build_sbox();
      step();
      step();
      chk_en = 1'b1;
      check("rst_ready", 128'(bus.oKeyRoundReady), 128'h0);
      check("rst_rdkey", bus.oRdKey, 128'h0);
      iRst = 1'b0;
      check("sbox_00", 128'(sbox_t[0]), 128'h63);
      check("sbox_53", 128'(sbox_t[8'h53]), 128'hed);
      expand(K128, 4);
      check("model_w4", 128'(sched[4]), 128'ha0fafe17);
      check("model_w43", 128'(sched[43]), 128'hb6630ca6);

      start(K128, 2'd3);
      check("inv_err", 128'(bus.oKeyErr), 128'h1);
      check("inv_busy", 128'(bus.oBusy), 128'h0);
      step();
      check("inv_err_gone", 128'(bus.oKeyErr), 128'h0);

      start(K256, 2'd2);
      check("nk4_err", 128'(bus4.oKeyErr), 128'h1);
      check("nk4_busy", 128'(bus4.oBusy), 128'h0);
      check("a256_ready_e0", 128'(bus.oKeyRoundReady), 128'h3);
      run(51);
      check("a256_done_e51", 128'(bus.oDone), 128'h0);
      step();
      check("a256_done_e52", 128'(bus.oDone), 128'h1);
      bus.iRdRound = 4'd14;
      step();
      check("a256_r14", bus.oRdKey, {32'h706c631e, 32'h046df344, 32'he6188d0b, 32'hfe4890d1});

      start(K128, 2'd0);
      check("done_start_ignored", 128'(bus.oDone), 128'h1);
      bus.iEnd = 1'b1;
      start(K128, 2'd0);
      check("end_wins_busy", 128'(bus.oBusy), 128'h0);
      check("end_wins_done", 128'(bus.oDone), 128'h0);

      start(K128, 2'd0);
      bus.iEnd = 1'b0;
      check("idle_end_start", 128'(bus.oBusy), 128'h1);
      run(39);
      check("a128_done_e39", 128'(bus.oDone), 128'h0);
      step();
      check("a128_done_e40", 128'(bus.oDone), 128'h1);
      check("a128_ready", 128'(bus.oKeyRoundReady), 128'h7ff);
      bus.iRdRound = 4'd10;
      step();
      check("a128_r10", bus.oRdKey, R10_128);
      bus.iRdRound = 4'd1;
      step();
      check("a128_r1", bus.oRdKey, {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17});
      bus.iEnd = 1'b1;
      step();
      bus.iEnd = 1'b0;
      bus.iRdRound = 4'd10;
      step();
`ifdef KEYEXP_ZEROIZE_EN
      check("zeroize_r10", bus.oRdKey, 128'h0);
`else
      check("retain_r10", bus.oRdKey, R10_128);
`endif

      start(K192, 2'd1);
      run(45);
      check("a192_done_e45", 128'(bus.oDone), 128'h0);
      step();
      check("a192_done_e46", 128'(bus.oDone), 128'h1);
      bus.iRdRound = 4'd12;
      step();
      check("a192_r12", bus.oRdKey, {32'h01002202, 32'h8ecc7204, 32'h448c773c, 32'he98ba06f});
      bus.iEnd = 1'b1;
      step();
      bus.iEnd = 1'b0;

      start(K128, 2'd0);
      run(19);
      bus.iEnd = 1'b1;
      step();
      bus.iEnd = 1'b0;
      check("abort_ready", 128'(bus.oKeyRoundReady), 128'h0);
      check("abort_busy", 128'(bus.oBusy), 128'h0);
      step();
      start(K128, 2'd0);
      run(39);
      check("restart_done_e61", 128'(bus.oDone), 128'h0);
      step();
      check("restart_done_e62", 128'(bus.oDone), 128'h1);
      bus.iRdRound = 4'd10;
      step();
      check("restart_r10", bus.oRdKey, R10_128);
      bus.iEnd = 1'b1;
      step();
      bus.iEnd = 1'b0;

      start(K192, 2'd1);
      run(10);
      iRst = 1'b1;
      step();
      iRst = 1'b0;
      check("rst_run_busy", 128'(bus.oBusy), 128'h0);
      check("rst_run_ready", 128'(bus.oKeyRoundReady), 128'h0);
      check("rst_run_rdkey", bus.oRdKey, 128'h0);

      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 3) == 0)
            bus.iKey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         bus.iStartKey = $urandom_range(0, 3) == 0;
         bus.iKeyLen   = 2'($urandom_range(0, 3));
         bus.iEnd      = $urandom_range(0, 39) == 0;
         bus.iRdRound  = 4'($urandom_range(0, 15));
         iRst          = $urandom_range(0, 299) == 0;
         step();
      end
      bus.iStartKey = 1'b0;
      bus.iEnd = 1'b0;
      iRst = 1'b0;
      step();
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
